// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, datapath selects.
// S_MDWAIT exists only when MULTICYCLE_CTRL_MULDIV_EN is defined.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_FAULT  = 4'd6
`ifdef MULTICYCLE_CTRL_MULDIV_EN
        , S_MDWAIT = 4'd7
`endif
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
        C_LUI, C_AUIPC, C_MULDIV, C_ILLEGAL
    } opclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] SRC_A_PC   = 2'd0;
    localparam logic [1:0] SRC_A_RS1  = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_MULDIV = 2'd2;
    localparam logic [1:0] WB_PC4    = 2'd3;

endpackage

// File: rtl/ctrl_opclass.sv
// Combinational opcode-to-class decoder; funct7 only separates mul/div from plain R-type.
module ctrl_opclass
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_funct7,
    output opclass_t   o_class
);

    always_comb begin
        o_class = C_ILLEGAL;
        case (i_opcode)
            OP_R:      o_class = (i_funct7 == F7_MULDIV) ? C_MULDIV : C_R;
            OP_I:      o_class = C_I;
            OP_LOAD:   o_class = C_LOAD;
            OP_STORE:  o_class = C_STORE;
            OP_BRANCH: o_class = C_BRANCH;
            OP_JAL:    o_class = C_JAL;
            OP_JALR:   o_class = C_JALR;
            OP_LUI:    o_class = C_LUI;
            OP_AUIPC:  o_class = C_AUIPC;
            default:   o_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory-wait timeout; MULTICYCLE_CTRL_MULDIV_EN adds the
// mul/div handshake (md_start/md_done, MDWAIT).
//   state  | meaning
//   IDLE   | after reset, go fetch
//   FETCH  | instruction read, wait for mem_ready
//   DECODE | classify opcode
//   EXEC   | ALU step for the instruction class
//   MEM    | data load/store, wait for mem_ready
//   MDWAIT | wait for mul/div unit
//   WB     | register write-back
//   FAULT  | sticky error until reset
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        clk,
    input  logic        nreset,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
`ifdef MULTICYCLE_CTRL_MULDIV_EN
    output logic        o_md_start,
    input  logic        i_md_done,
`endif
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_i_or_d,
    output logic        o_pc_write,
    output logic        o_ir_write,
    output logic        o_reg_write,
    output logic        o_branch,
    output logic [1:0]  o_alu_op,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_wb_sel,
    output logic        o_fault,
    output logic [3:0]  o_state
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    opclass_t   w_class;
    logic       w_waiting;
    logic       w_timeout;
    logic       w_unused_instr;

    assign w_unused_instr = ^i_instr[24:7];

    ctrl_opclass u_opclass (
        .i_opcode (i_instr[6:0]),
        .i_funct7 (i_instr[31:25]),
        .o_class  (w_class)
    );

    always_comb begin
        w_waiting = 1'b0;
        case (r_state)
            S_FETCH, S_MEM: w_waiting = !i_mem_ready;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
            S_MDWAIT:       w_waiting = !i_md_done;
`endif
            default:        w_waiting = 1'b0;
        endcase
    end

    // Fault on the wait cycle that brings the count up to the limit.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_waiting
                       && ((int'(r_wait_cnt) + 1) == TIMEOUT_CYCLES);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_class)
                    C_ILLEGAL: w_next = S_FAULT;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
                    C_MULDIV:  w_next = S_EXEC;
`else
                    C_MULDIV:  w_next = S_FAULT;
`endif
                    default:   w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (w_class)
                    C_LOAD, C_STORE: w_next = S_MEM;
                    C_BRANCH:        w_next = S_FETCH;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
                    C_MULDIV:        w_next = S_MDWAIT;
`endif
                    default:         w_next = S_WB;
                endcase
            end
            S_MEM:    if (i_mem_ready) w_next = (w_class == C_LOAD) ? S_WB : S_FETCH;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
            S_MDWAIT: if (i_md_done) w_next = S_WB;
`endif
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_FAULT;
        endcase
        if (w_timeout) w_next = S_FAULT;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= 8'd0;
            else if (w_waiting && r_wait_cnt != 8'hFF)
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_i_or_d    = 1'b0;
        o_pc_write  = 1'b0;
        o_ir_write  = 1'b0;
        o_reg_write = 1'b0;
        o_branch    = 1'b0;
        o_alu_op    = ALU_ADD;
        o_alu_src_a = SRC_A_PC;
        o_alu_src_b = SRC_B_RS2;
        o_wb_sel    = WB_ALU;
        o_fault     = 1'b0;
        o_state     = r_state;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
        o_md_start  = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write  = 1'b1;
                    o_pc_write  = 1'b1;
                    o_alu_src_b = SRC_B_FOUR;
                end
            end
            S_EXEC: begin
                case (w_class)
                    C_R:     begin o_alu_op = ALU_FUNCT; o_alu_src_a = SRC_A_RS1; end
                    C_I:     begin o_alu_op = ALU_FUNCT; o_alu_src_a = SRC_A_RS1; o_alu_src_b = SRC_B_IMM; end
                    C_LOAD,
                    C_STORE: begin o_alu_src_a = SRC_A_RS1; o_alu_src_b = SRC_B_IMM; end
                    C_BRANCH: begin
                        o_alu_op    = ALU_SUB;
                        o_alu_src_a = SRC_A_RS1;
                        o_branch    = 1'b1;
                    end
                    C_JAL:   begin o_pc_write = 1'b1; o_alu_src_b = SRC_B_IMM; end
                    C_JALR:  begin o_pc_write = 1'b1; o_alu_src_a = SRC_A_RS1; o_alu_src_b = SRC_B_IMM; end
                    C_LUI:   begin o_alu_op = ALU_PASSB; o_alu_src_b = SRC_B_IMM; end
                    C_AUIPC: o_alu_src_b = SRC_B_IMM;
`ifdef MULTICYCLE_CTRL_MULDIV_EN
                    C_MULDIV: begin
                        o_md_start  = 1'b1;
                        o_alu_op    = ALU_FUNCT;
                        o_alu_src_a = SRC_A_RS1;
                    end
`endif
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_i_or_d  = 1'b1;
                o_mem_we  = (w_class == C_STORE);
            end
            S_WB: begin
                o_reg_write = 1'b1;
                case (w_class)
                    C_LOAD:         o_wb_sel = WB_MEM;
                    C_JAL, C_JALR:  o_wb_sel = WB_PC4;
                    C_MULDIV:       o_wb_sel = WB_MULDIV;
                    default:        o_wb_sel = WB_ALU;
                endcase
            end
            S_FAULT: o_fault = 1'b1;
            default: o_fault = 1'b0;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum memory-wait cycles before fault; 0 disables the timeout.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 nreset  in  1  reset, asynchronous, active-low.
REQ-004 instr  in  32  current instruction-register contents; valid from DECODE onward.
REQ-005 mem_ready  in  1  memory handshake completion for the current request.
REQ-006 mem_req, mem_we, i_or_d  out  1 each  memory request, write enable, address select (0 = PC, 1 = ALU result).
REQ-007 pc_write, ir_write, reg_write, branch  out  1 each  datapath write enables; branch makes pc_write conditional on the ALU zero flag.
REQ-008 alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded, 11 pass B.
REQ-009 alu_src_a  out  2  0 PC, 1 rs1, 2 zero; alu_src_b  out  2  0 rs2, 1 constant 4, 2 immediate.
REQ-010 wb_sel  out  2  0 ALU result, 1 memory data, 2 muldiv result, 3 PC+4.
REQ-011 fault  out  1  sticky error flag; state  out  4  debug copy of the state register.

Function
REQ-012 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and FAULT (plus MDWAIT, see REQ-029); outputs SHALL be a combinational decode of the registered state, instr[6:0] and mem_ready.
REQ-013 IDLE: all outputs 0; SHALL move to FETCH on the first clock edge after reset release.
REQ-014 FETCH: mem_req=1, i_or_d=0; hold until mem_ready=1.
REQ-015 In the FETCH cycle with mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1, alu_op=00; next state DECODE.
REQ-016 DECODE SHALL classify instr[6:0]:
- 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC
- any other opcode: FAULT.
REQ-017 EXEC for R and I-ALU: alu_op=10, alu_src_a=1, alu_src_b=0 (R) or 2 (I); next WB with wb_sel=0, reg_write=1.
REQ-018 EXEC for LOAD/STORE: alu_op=00, alu_src_a=1, alu_src_b=2; next MEM.
REQ-019 MEM: mem_req=1, i_or_d=1, mem_we=1 for STORE only; hold until mem_ready.
- LOAD then goes to WB with wb_sel=1.
- STORE then goes to FETCH.
REQ-020 EXEC for BRANCH: alu_op=01, alu_src_a=1, alu_src_b=0, branch=1; next FETCH.
REQ-021 JAL/JALR EXEC: pc_write=1, alu_op=00, alu_src_a=0 (JAL) or 1 (JALR), alu_src_b=2; next WB with wb_sel=3.
REQ-022 LUI EXEC: alu_op=11, alu_src_b=2. AUIPC EXEC: alu_op=00, alu_src_a=0, alu_src_b=2. Both go to WB with wb_sel=0.
REQ-023 WB: reg_write=1 for exactly one cycle; next FETCH.
REQ-024 Latency with mem_ready tied high: R/I/LUI/AUIPC/JAL/JALR 4 cycles; LOAD 5; STORE 4; BRANCH 3.
REQ-025 An 8-bit wait counter SHALL count FETCH/MEM cycles with mem_ready=0 and clear on each state change.
REQ-026 When TIMEOUT_CYCLES≠0 and the wait counter reaches TIMEOUT_CYCLES, the next state SHALL be FAULT.
REQ-027 FAULT: fault=1, all enables 0; remain there until reset.

Reset
REQ-028 nreset low SHALL force state=IDLE, wait counter=0 and all outputs 0 immediately, including mid-memory-handshake; no pending request is resumed after release.

Configuration
REQ-029 Macro MULTICYCLE_CTRL_MULDIV_EN defined: adds ports md_start (out, 1) and md_done (in, 1) and state MDWAIT.
- R-type with funct7=0000001: EXEC pulses md_start for one cycle, then MDWAIT.
- MDWAIT holds until md_done=1, then WB with wb_sel=2.
- The REQ-025/026 timeout SHALL also apply in MDWAIT.
REQ-030 Macro undefined: no md ports and no MDWAIT; R-type with funct7=0000001 SHALL go to FAULT.

Structure
REQ-031 Package ctrl_pkg SHALL hold the state encoding, opcode constants, and the alu_op, alu_src and wb_sel encodings.
REQ-032 Sub-module ctrl_opclass (combinational opcode-to-class decoder) SHALL be instantiated once.

Verification
REQ-033 mem_ready=1, instr=0x00208033 (add) -> IDLE, FETCH, DECODE, EXEC(alu_op=10), WB(reg_write=1), FETCH; 4 cycles per instruction.
REQ-034 instr=0x0000A083 (lw), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, i_or_d=1, mem_we=0, then WB with wb_sel=1.
REQ-035 TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> FAULT after the 4th wait cycle; fault=1 persists until nreset.
REQ-036 instr=0x0000007F (illegal opcode) -> DECODE then FAULT; no reg_write or pc_write pulse.
REQ-037 nreset asserted during MEM of a store -> mem_req and mem_we drop to 0 asynchronously; after release the sequence is IDLE then FETCH.
REQ-038 MULDIV_EN, instr=0x022081B3 (mul), md_done after 5 cycles -> single md_start pulse, MDWAIT for 5 cycles, then WB with wb_sel=2.
